// File: rtl/nios0_sobel_result.sv
// Avalon-MM slave that buffers 24-bit Sobel pixel results in a FIFO for the Nios II.
// Provides pop/status/control/command registers and a level-threshold interrupt.
module nios0_sobel_result #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        irq
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [23:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]   count_r, count_s, threshold_r, threshold_s;
    logic              stall_r, stall_s, irq_en_r, irq_en_s, irq_r, irq_s;
    logic              in_ready_r, in_ready_s;
    logic [31:0]       readdata_r, readdata_s, status_s, ctrl_s;
    logic              rd_s, wr_s, empty_s, full_s, push_s, pop_s, flush_s, clr_s;
    logic              unused_s;

    assign unused_s = ^{writedata[31:ADDR_W+9], writedata[7:2]};

    // Bus strobe decode and FIFO occupancy flags
    always_comb begin
        rd_s    = chipselect & ~read_n;
        wr_s    = chipselect & ~write_n;
        empty_s = (count_r == '0);
        full_s  = (count_r == FULL_CNT);
        push_s  = in_valid & ~full_s;
        pop_s   = rd_s & (address == 2'd0) & ~empty_s;
        flush_s = wr_s & (address == 2'd3) & writedata[1];
        clr_s   = wr_s & (address == 2'd3) & writedata[0];
    end

    // Next-state for pointers, count, stall, control and interrupt
    always_comb begin
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        count_s     = count_r;
        irq_en_s    = irq_en_r;
        threshold_s = threshold_r;
        if (flush_s) begin
            wr_ptr_s = '0;
            rd_ptr_s = '0;
            count_s  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
        // A new overflow in the same cycle as a clear keeps the flag set
        if (in_valid & full_s) begin
            stall_s = 1'b1;
        end else if (clr_s) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_r;
        end
        if (wr_s & (address == 2'd2)) begin
            irq_en_s    = writedata[0];
            threshold_s = writedata[ADDR_W+8:8];
        end else begin
            irq_en_s    = irq_en_r;
            threshold_s = threshold_r;
        end
        in_ready_s = (count_s != FULL_CNT);
        irq_s      = irq_en_r & (threshold_r != '0) & (count_r >= threshold_r);
    end

    // Register read mux; STATUS reflects state before this cycle's update
    always_comb begin
        status_s               = 32'h0000_0000;
        status_s[ADDR_W:0]     = count_r;
        status_s[16]           = empty_s;
        status_s[17]           = full_s;
        status_s[18]           = stall_r;
        status_s[19]           = irq_r;
        ctrl_s                 = 32'h0000_0000;
        ctrl_s[0]              = irq_en_r;
        ctrl_s[ADDR_W+8:8]     = threshold_r;
        readdata_s             = readdata_r;
        if (rd_s) begin
            case (address)
                2'd0: begin
                    if (empty_s) begin
                        readdata_s = 32'h0000_0000;
                    end else begin
                        readdata_s = {7'b0, 1'b1, mem_r[rd_ptr_r]};
                    end
                end
                2'd1:    readdata_s = status_s;
                2'd2:    readdata_s = ctrl_s;
                default: readdata_s = 32'h0000_0000;
            endcase
        end else begin
            readdata_s = readdata_r;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_s & ~flush_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            threshold_r <= '0;
            stall_r     <= 1'b0;
            irq_en_r    <= 1'b0;
            irq_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            readdata_r  <= 32'h0000_0000;
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            threshold_r <= threshold_s;
            stall_r     <= stall_s;
            irq_en_r    <= irq_en_s;
            irq_r       <= irq_s;
            in_ready_r  <= in_ready_s;
            readdata_r  <= readdata_s;
        end
    end

    assign readdata = readdata_r;
    assign in_ready = in_ready_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_nios0_sobel_result.sv
// Randomised self-checking bench for nios0_sobel_result against a queue-based model.
module tb_nios0_sobel_result;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] q[$];
    bit          m_stall, m_en, m_irq;
    int          m_thr;
    logic [31:0] exp_rd;

    nios0_sobel_result #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_stall = 1'b0;
        m_en    = 1'b0;
        m_thr   = 0;
        m_irq   = 1'b0;
        exp_rd  = 32'h0;
    endtask

    task automatic idle();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_valid = 1'b0;
    endtask

    // One clock with the currently driven inputs; model advances alongside.
    task automatic cycle();
        int sz;
        bit ready, push, rd, wr, pop, flush, clr, nirq;
        logic [23:0] d;
        logic [31:0] wd;
        logic [1:0]  a;
        sz = q.size(); ready = (sz != DEPTH); push = in_valid && ready;
        rd = chipselect && !read_n; wr = chipselect && !write_n;
        a = address; wd = writedata; d = in_data;
        pop = rd && (a == 2'd0) && (sz > 0);
        flush = wr && (a == 2'd3) && wd[1];
        clr = wr && (a == 2'd3) && wd[0];
        nirq = m_en && (m_thr != 0) && (sz >= m_thr);
        if (rd) begin
            exp_rd = 32'h0;
            if (a == 2'd0 && sz > 0) exp_rd = {8'h01, q[0]};
            if (a == 2'd1) begin
                exp_rd[ADDR_W:0] = (ADDR_W + 1)'(sz);
                exp_rd[16] = (sz == 0); exp_rd[17] = (sz == DEPTH);
                exp_rd[18] = m_stall;   exp_rd[19] = m_irq;
            end
            if (a == 2'd2) begin
                exp_rd[0] = m_en;
                exp_rd[ADDR_W+8:8] = (ADDR_W + 1)'(m_thr);
            end
        end
        @(posedge clk);
        if (wr && a == 2'd2) begin
            m_en = wd[0];
            m_thr = int'(wd[ADDR_W+8:8]);
        end
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        if (in_valid && !ready) m_stall = 1'b1;
        else if (clr) m_stall = 1'b0;
        m_irq = nirq;
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        cycle();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = 24'($urandom());
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h exp 0", readdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b exp 1", in_ready); end
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0001_0000) begin n_err++; $display("FAIL reset_status got %h exp 00010000", readdata); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 24'h112233; cycle();
        in_data = 24'h445566; cycle();
        in_valid = 1'b0;
        cpu_read(2'd0);
        n_vec++; if (readdata !== 32'h0111_2233) begin n_err++; $display("FAIL basic_rd1 got %h exp 01112233", readdata); end
        cpu_read(2'd0);
        n_vec++; if (readdata !== 32'h0144_5566) begin n_err++; $display("FAIL basic_rd2 got %h exp 01445566", readdata); end
        cpu_read(2'd0);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL basic_rd3 got %h exp 0", readdata); end
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0001_0000) begin n_err++; $display("FAIL basic_status got %h exp 00010000", readdata); end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1; in_data = 24'($urandom());
            cycle();
            n_vec++;
            if (in_ready !== (i < 15)) begin n_err++; $display("FAIL full_rdy[%0d] got %b exp %b", i, in_ready, i < 15); end
        end
        cpu_write(2'd3, 32'h1);
        in_valid = 1'b0;
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0006_0010) begin n_err++; $display("FAIL full_status_set_wins got %h exp 00060010", readdata); end
        cpu_write(2'd3, 32'h1);
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0002_0010) begin n_err++; $display("FAIL full_status_clr got %h exp 00020010", readdata); end
        cpu_write(2'd3, 32'h2);
    endtask

    task automatic test_push_pop();
        logic [23:0] base;
        push_n(5);
        base = 24'($urandom());
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = base + 24'(i);
            cpu_read(2'd0);
            n_vec++; if (readdata !== exp_rd) begin n_err++; $display("FAIL pp_data[%0d] got %h exp %h", i, readdata, exp_rd); end
        end
        in_valid = 1'b0;
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0000_0005) begin n_err++; $display("FAIL pp_count got %h exp 00000005", readdata); end
        for (int i = 0; i < 5; i++) begin
            cpu_read(2'd0);
            n_vec++; if (readdata !== {8'h01, base + 24'(15 + i)}) begin n_err++; $display("FAIL pp_tail[%0d] got %h exp %h", i, readdata, {8'h01, base + 24'(15 + i)}); end
        end
    endtask

    task automatic test_irq();
        cpu_write(2'd2, 32'h0000_0401);
        push_n(4);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b exp 0", irq); end
        cycle();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b exp 1", irq); end
        cpu_read(2'd0);
        cycle();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got %b exp 0", irq); end
        cpu_write(2'd2, 32'h0000_0001);
        push_n(6);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_thr0[%0d] got %b exp 0", i, irq); end
        end
        cpu_write(2'd3, 32'h2);
        cpu_write(2'd2, 32'h0);
    endtask

    task automatic test_flush_push();
        push_n(7);
        in_valid = 1'b1; in_data = 24'hABCDEF;
        cpu_write(2'd3, 32'h2);
        in_valid = 1'b0;
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0001_0000) begin n_err++; $display("FAIL flush_status got %h exp 00010000", readdata); end
        cpu_read(2'd0);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL flush_data got %h exp 0", readdata); end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 99) < 55);
            in_data = 24'($urandom());
            op = $urandom_range(0, 19);
            if (op < 6) cpu_read(2'd0);
            else if (op < 8) cpu_read(2'd1);
            else if (op == 8) cpu_read(2'd2);
            else if (op == 9) cpu_read(2'd3);
            else if (op == 10) cpu_write(2'd2, {19'h0, 5'($urandom_range(0, 20)), 7'h0, 1'($urandom())});
            else if (op == 11 && $urandom_range(0, 3) == 0) cpu_write(2'd3, 32'($urandom_range(0, 3)));
            else if (op == 12) cpu_write(2'd0, $urandom());
            else cycle();
            n_vec++; if (readdata !== exp_rd) begin n_err++; $display("FAIL rand_rd[%0d] got %h exp %h", i, readdata, exp_rd); end
            n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq[%0d] got %b exp %b", i, irq, m_irq); end
            n_vec++; if (in_ready !== (q.size() != DEPTH)) begin n_err++; $display("FAIL rand_rdy[%0d] got %b exp %b", i, in_ready, q.size() != DEPTH); end
        end
        idle();
        cpu_write(2'd3, 32'h3);
        cpu_write(2'd2, 32'h0);
    endtask

    task automatic test_reset_mid();
        cpu_write(2'd2, 32'h0000_0201);
        push_n(8);
        cycle();
        cpu_read(2'd1);
        n_vec++; if (irq !== 1'b1 || readdata === 32'h0) begin n_err++; $display("FAIL mid_pre irq %b rd %h exp irq 1 rd nonzero", irq, readdata); end
        in_valid = 1'b1; in_data = 24'h123456;
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL mid_rd got %h exp 0", readdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got %b exp 0", irq); end
        model_clear();
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rdy got %b exp 1", in_ready); end
        cpu_read(2'd1);
        n_vec++; if (readdata !== 32'h0001_0000) begin n_err++; $display("FAIL mid_status got %h exp 00010000", readdata); end
    endtask

    initial begin
        idle();
        in_data = 24'h0;
        model_clear();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_basic();
        test_full_stall();
        test_push_pop();
        test_irq();
        test_flush_push();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nios0_sobel_result.md
Name: nios0_sobel_result

Overview:
- Avalon-MM slave that carries 24-bit pixel results from the Sobel fabric back into the Nios II.
- It is the read-direction counterpart of the CPU-written 24-bit output ports.
- Fabric writes results in through a valid/ready stream, and a parameterised FIFO buffers them.
- CPU pops pixels, polls status and gets an optional level-threshold interrupt.

Parameters:
DEPTH, 16, FIFO depth in 24-bit words; power of two, 2..256
ADDR_W, 4, log2(DEPTH); FIFO pointer width

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, registered, read latency 1
in_data  in  24  pixel from Sobel datapath ({R,G,B} or replicated gray)
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a word this cycle
irq  out  1  level interrupt to CPU

Behaviour:
- Reset (async, reset_n=0): FIFO empty, count=0, pointers=0, readdata=0, stall=0, irq_en=0, threshold=0, irq=0, in_ready=1 after reset.
- Strobes:
  - rd = chipselect & ~read_n.
  - wr = chipselect & ~write_n.
  - rd and wr asserted together: illegal; wr takes effect and readdata is still updated.
- Push:
  - Occurs when in_valid & in_ready.
  - Word is written at the write pointer; the pointer wraps modulo DEPTH.
- in_ready = (count != DEPTH).
  - Depends on registered count only; no same-cycle pop bypass.
  - When full, a push is refused even if a pop occurs that cycle.
- Stall flag: set (sticky) on any cycle with in_valid & ~in_ready; cleared only by a CPU write.
- Register map, address 0 (DATA, read):
  - readdata <= {7'b0, ~empty, head_word}.
  - Read while non-empty pops (read pointer +1, wraps).
  - Read while empty returns 0 and changes no state.
  - Writes to address 0 are ignored.
- Register map, address 1 (STATUS, read-only):
  - [ADDR_W:0] count; [16] empty; [17] full; [18] stall; [19] irq.
  - Value is sampled in the strobe cycle, i.e. before that cycle's push/pop update.
- Register map, address 2 (CTRL, R/W):
  - [0] irq_en; [ADDR_W+8:8] threshold.
  - Reads return the stored value with other bits 0.
- Register map, address 3 (CMD, write-only, reads 0):
  - Bit 0 = 1 clears stall.
  - Bit 1 = 1 flushes the FIFO (pointers and count -> 0).
  - Bit 0 and bit 1 are independent.
- readdata: updated in the cycle after rd is sampled and held until the next rd. Reads of unmapped bits return 0.
- count:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Push into empty FIFO with a simultaneous pop: pop sees empty and returns 0; the push lands, count=1.
- Flush in the same cycle as a push or pop: flush wins; count=0 and the incoming word is dropped.
- Stall clear in the same cycle as a new stall condition: set wins.
- irq:
  - irq = irq_en & (threshold != 0) & (count >= threshold), where count is the post-update registered value.
  - irq is registered and asserts one cycle after count reaches the threshold.
  - Threshold > DEPTH never fires.
- Reset mid-operation: all state clears immediately; FIFO contents become don't-care and are unreadable until pushed again.

Test Plan:
- Reset, then push 0x112233, 0x445566; read addr0 twice, then a third time:
  - Reads 1 and 2 return 0x01112233 then 0x01445566.
  - Read 3 returns 0x00000000.
  - STATUS returns empty=1, count=0.
- Push 16 words with in_valid held high for 18 cycles:
  - in_ready drops after the 16th accept.
  - STATUS = count 16, full=1, stall=1.
  - Write addr3=1 while in_valid is high -> stall stays 1 (set wins).
  - Write addr3=1 with in_valid low -> stall reads 0.
- FIFO at count 5; push and pop in the same cycle for 20 cycles with an incrementing pattern:
  - count stays 5 throughout.
  - Data pops in order across the pointer wrap.
- CTRL = 0x0401 (en=1, threshold=4); push 4 words:
  - irq rises one cycle after the 4th accept.
  - One pop -> irq falls.
  - CTRL = 0x0001 -> irq stays 0 at any count.
- FIFO holding 7 words; write addr3=2 in the same cycle as a push:
  - count=0, empty=1; the pushed word is not readable.
  - Read addr0 returns 0.
- Assert reset_n low mid-burst with the FIFO half full:
  - readdata, irq and count become 0 asynchronously; in_ready=1 after release.
